// File: rtl/ssd_scan_capture.sv
// Receiver for the multiplexed 8-digit seven-segment scan bus. It waits for each digit slot to settle,
// decodes the segment pattern back to a hex nibble, and presents all eight digits in parallel with valid/bad flags.
module ssd_scan_capture #(
    parameter int N_SETTLE  = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  An,
    input  logic [7:0]  Cath,
    output logic [31:0] Digits,
    output logic [7:0]  Dp_out,
    output logic [7:0]  Valid,
    output logic [7:0]  Bad,
    output logic        Frame_done,
    output logic        Stalled
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0]           SETTLE_LAST = 8'(N_SETTLE - 1);
    localparam logic [TIMEOUT_W-1:0] WD_MAX      = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] WD_ONE      = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    // True when exactly one anode is driven low.
    function automatic logic anode_legal(input logic [7:0] an);
        return ($countones(~an) == 32'd1);
    endfunction

    function automatic logic [2:0] anode_idx(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Returns {match, nibble} for an active-low abcdefg pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = {1'b1, 4'h0};
            7'b1001111: res = {1'b1, 4'h1};
            7'b0010010: res = {1'b1, 4'h2};
            7'b0000110: res = {1'b1, 4'h3};
            7'b1001100: res = {1'b1, 4'h4};
            7'b0100100: res = {1'b1, 4'h5};
            7'b0100000: res = {1'b1, 4'h6};
            7'b0001111: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0000100: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b1100000: res = {1'b1, 4'hB};
            7'b0110001: res = {1'b1, 4'hC};
            7'b1000010: res = {1'b1, 4'hD};
            7'b0110000: res = {1'b1, 4'hE};
            7'b0111000: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [7:0]           cath_s1_q, cath_s1_d, cath_s2_q, cath_s2_d;
    logic [7:0]           lat_an_q, lat_an_d, lat_cath_q, lat_cath_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [7:0]           seen_q, seen_d;
    logic [31:0]          digits_q, digits_d;
    logic [7:0]           dp_q, dp_d, valid_q, valid_d, bad_q, bad_d;
    logic                 fd_q, fd_d, stalled_q, stalled_d;
    logic [4:0]           dec_s;
    logic [7:0]           seen_nxt_s;

    // Next-state logic for the synchronisers, slot FSM, capture registers and watchdog.
    always_comb begin
        an_s1_d    = An;
        an_s2_d    = an_s1_q;
        cath_s1_d  = Cath;
        cath_s2_d  = cath_s1_q;
        state_d    = state_q;
        lat_an_d   = lat_an_q;
        lat_cath_d = lat_cath_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        valid_d    = valid_q;
        bad_d      = bad_q;
        fd_d       = 1'b0;
        stalled_d  = stalled_q;
        wd_d       = (wd_q == WD_MAX) ? wd_q : (wd_q + WD_ONE);
        dec_s      = seg_decode(lat_cath_q[7:1]);
        seen_nxt_s = seen_q | (8'b0000_0001 << idx_q);

        case (state_q)
            ST_IDLE: begin
                if (anode_legal(an_s2_q)) begin
                    lat_an_d   = an_s2_q;
                    lat_cath_d = cath_s2_q;
                    idx_d      = anode_idx(an_s2_q);
                    cnt_d      = 8'd0;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (an_s2_q != lat_an_q) begin
                    if (anode_legal(an_s2_q)) begin
                        lat_an_d   = an_s2_q;
                        lat_cath_d = cath_s2_q;
                        idx_d      = anode_idx(an_s2_q);
                        cnt_d      = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cath_s2_q != lat_cath_q) begin
                    lat_cath_d = cath_s2_q;
                    cnt_d      = 8'd0;
                end else if (cnt_q >= SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (dec_s[4]) begin
                    digits_d[{idx_q, 2'b00} +: 4] = dec_s[3:0];
                    valid_d[idx_q]                = 1'b1;
                    bad_d[idx_q]                  = 1'b0;
                end else begin
                    valid_d[idx_q] = 1'b0;
                    bad_d[idx_q]   = 1'b1;
                end
                dp_d[idx_q] = ~lat_cath_q[0];
                if (&seen_nxt_s) begin
                    fd_d   = 1'b1;
                    seen_d = 8'h00;
                end else begin
                    seen_d = seen_nxt_s;
                end
                wd_d      = {TIMEOUT_W{1'b0}};
                stalled_d = 1'b0;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (an_s2_q == lat_an_q) begin
                    state_d = ST_HOLD;
                end else if (anode_legal(an_s2_q)) begin
                    lat_an_d   = an_s2_q;
                    lat_cath_d = cath_s2_q;
                    idx_d      = anode_idx(an_s2_q);
                    cnt_d      = 8'd0;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A sample in the same cycle as expiry wins, since it forces wd_d to zero.
        if ((state_q != ST_SAMPLE) && (wd_d == WD_MAX)) begin
            stalled_d = 1'b1;
            valid_d   = 8'h00;
            seen_d    = 8'h00;
        end else begin
            stalled_d = stalled_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_s1_q    <= 8'hFF;
            an_s2_q    <= 8'hFF;
            cath_s1_q  <= 8'hFF;
            cath_s2_q  <= 8'hFF;
            state_q    <= ST_IDLE;
            lat_an_q   <= 8'hFF;
            lat_cath_q <= 8'hFF;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            wd_q       <= {TIMEOUT_W{1'b0}};
            seen_q     <= 8'h00;
            digits_q   <= 32'h0000_0000;
            dp_q       <= 8'h00;
            valid_q    <= 8'h00;
            bad_q      <= 8'h00;
            fd_q       <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            an_s1_q    <= an_s1_d;
            an_s2_q    <= an_s2_d;
            cath_s1_q  <= cath_s1_d;
            cath_s2_q  <= cath_s2_d;
            state_q    <= state_d;
            lat_an_q   <= lat_an_d;
            lat_cath_q <= lat_cath_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            seen_q     <= seen_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            valid_q    <= valid_d;
            bad_q      <= bad_d;
            fd_q       <= fd_d;
            stalled_q  <= stalled_d;
        end
    end

    assign Digits     = digits_q;
    assign Dp_out     = dp_q;
    assign Valid      = valid_q;
    assign Bad        = bad_q;
    assign Frame_done = fd_q;
    assign Stalled    = stalled_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Bench for ssd_scan_capture: directed scenarios plus randomized scan frames checked against a per-digit model.
module tb_ssd_scan_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  An;
    logic [7:0]  Cath;
    logic [31:0] Digits;
    logic [7:0]  Dp_out, Valid, Bad;
    logic        Frame_done, Stalled;

    int n_checks = 0;
    int n_err    = 0;
    int fd_cnt   = 0;

    logic [6:0] seg_tab [16];
    logic [3:0] m_dig   [8];
    logic       m_valid [8];
    logic       m_bad   [8];
    logic       m_dp    [8];
    logic       m_seen  [8];
    logic       m_stalled;
    int         m_frames;

    ssd_scan_capture #(.N_SETTLE(16), .TIMEOUT_W(12)) dut (
        .Clk(Clk), .Reset(Reset), .An(An), .Cath(Cath),
        .Digits(Digits), .Dp_out(Dp_out), .Valid(Valid), .Bad(Bad),
        .Frame_done(Frame_done), .Stalled(Stalled)
    );

    always #5 Clk = ~Clk;

    // Count every cycle Frame_done is high; a stuck pulse shows up as an over-count.
    always @(posedge Clk) begin
        if (Frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_dig[i] = 4'h0; m_valid[i] = 1'b0; m_bad[i] = 1'b0; m_dp[i] = 1'b0; m_seen[i] = 1'b0;
        end
        m_stalled = 1'b0;
    endtask

    // One settled slot of digit idx showing seg: look the pattern up in the glyph table.
    task automatic model_sample(input int idx, input logic [6:0] seg, input logic dp_lit);
        int hit = -1;
        int nseen = 0;
        for (int k = 0; k < 16; k++) if (hit < 0 && seg_tab[k] == seg) hit = k;
        if (hit >= 0) begin
            m_dig[idx] = 4'(hit); m_valid[idx] = 1'b1; m_bad[idx] = 1'b0;
        end else begin
            m_valid[idx] = 1'b0; m_bad[idx] = 1'b1;
        end
        m_dp[idx]   = dp_lit;
        m_seen[idx] = 1'b1;
        m_stalled   = 1'b0;
        for (int i = 0; i < 8; i++) nseen += int'(m_seen[i]);
        if (nseen == 8) begin
            m_frames++;
            for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
        end
    endtask

    task automatic model_stall();
        for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_seen[i] = 1'b0; end
        m_stalled = 1'b1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ed;
        logic [7:0]  ev, eb, ep;
        for (int i = 0; i < 8; i++) begin
            ed[4*i +: 4] = m_dig[i]; ev[i] = m_valid[i]; eb[i] = m_bad[i]; ep[i] = m_dp[i];
        end
        chk({tag, ".digits"}, Digits, ed);
        chk({tag, ".valid"}, {24'd0, Valid}, {24'd0, ev});
        chk({tag, ".bad"}, {24'd0, Bad}, {24'd0, eb});
        chk({tag, ".dp"}, {24'd0, Dp_out}, {24'd0, ep});
        chk({tag, ".frames"}, 32'(fd_cnt), 32'(m_frames));
        chk({tag, ".stalled"}, {31'd0, Stalled}, {31'd0, m_stalled});
    endtask

    // Two idle cycles, then hold digit idx with the given pattern for len cycles.
    task automatic drive_slot(input int idx, input logic [6:0] seg, input logic dp_lit, input int len);
        logic [7:0] one_hot;
        An = 8'hFF; Cath = 8'hFF;
        tick(2);
        one_hot = 8'd1 << idx;
        An   = ~one_hot;
        Cath = {seg, ~dp_lit};
        tick(len);
        model_sample(idx, seg, dp_lit);
    endtask

    initial begin
        int pi [8];
        int tmp, j, len;
        logic [6:0] seg;
        logic       dpl;
        logic [3:0] pi_digits [8];

        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        pi_digits = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
        m_frames = 0;
        model_reset();

        Reset = 1'b1; An = 8'hFF; Cath = 8'hFF;
        tick(3);
        Reset = 1'b0;
        tick(1);
        check_all("reset");

        // Pi scan at 2048 cycles per slot, decimal point on digit 2 only.
        for (int d = 0; d < 8; d++) drive_slot(d, seg_tab[pi_digits[d]], (d == 2), 2048);
        check_all("pi");
        chk("pi.const_digits", Digits, 32'h6295_1413);
        chk("pi.const_valid", {24'd0, Valid}, 32'h0000_00FF);
        chk("pi.const_dp", {24'd0, Dp_out}, 32'h0000_0004);

        // 5-cycle cathode glitch inside digit 0's settle window.
        An = 8'hFF; Cath = 8'hFF; tick(2);
        An = 8'hFE; Cath = {seg_tab[7], 1'b1}; tick(4);
        Cath = {seg_tab[8], 1'b1}; tick(5);
        Cath = {seg_tab[7], 1'b1}; tick(10);
        check_all("glitch.early");
        tick(24);
        model_sample(0, seg_tab[7], 1'b0);
        check_all("glitch.final");

        // Illegal glyph on digit 5, then a legal one clears the flag.
        drive_slot(5, 7'b1111110, 1'b0, 40);
        check_all("bad5");
        chk("bad5.const", {24'd0, Bad}, 32'h0000_0020);
        drive_slot(5, seg_tab[10], 1'b1, 40);
        check_all("bad5.clear");

        // Two anodes low is idle; a following single anode samples normally.
        An = 8'hFF; Cath = 8'hFF; tick(2);
        An = 8'hFC; Cath = {seg_tab[12], 1'b1}; tick(1000);
        check_all("two_anodes");
        An = 8'hFE; tick(40);
        model_sample(0, seg_tab[12], 1'b0);
        check_all("two_anodes.follow");

        // Randomized frames in shuffled slot order, occasionally illegal patterns.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 8; i++) pi[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(0, i)); tmp = pi[i]; pi[i] = pi[j]; pi[j] = tmp;
            end
            for (int i = 0; i < 8; i++) begin
                seg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
                dpl = 1'($urandom);
                len = int'($urandom_range(24, 80));
                drive_slot(pi[i], seg, dpl, len);
                check_all("rand");
            end
        end

        // Watchdog: idle bus long enough to expire, then a slot clears it.
        drive_slot(3, seg_tab[4], 1'b0, 40);
        An = 8'hFF; Cath = 8'hFF; tick(4000);
        check_all("wd.before");
        tick(200);
        model_stall();
        check_all("wd.expired");
        drive_slot(1, seg_tab[14], 1'b0, 40);
        check_all("wd.resume");

        // Reset in the middle of digit 3's settle window.
        An = 8'hFF; Cath = 8'hFF; tick(2);
        An = 8'hF7; Cath = {seg_tab[9], 1'b0}; tick(8);
        Reset = 1'b1; An = 8'hFF; Cath = 8'hFF; tick(1);
        Reset = 1'b0;
        model_reset();
        check_all("mid_reset");
        tick(40);
        check_all("mid_reset.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
